// File: rtl/emulador_de_teclado_if.sv
// Key command handshake between the injecting side (master) and the keypad emulator (slave).
interface emulador_de_teclado_if;
  logic [3:0] key_value;
  logic       key_start;
  logic       key_ready;
  logic       busy;
  logic       done;
  logic       key_err;

  modport master (
    output key_value,
    output key_start,
    input  key_ready,
    input  busy,
    input  done,
    input  key_err
  );

  modport slave (
    input  key_value,
    input  key_start,
    output key_ready,
    output busy,
    output done,
    output key_err
  );
endinterface

// File: rtl/emulador_de_teclado.sv
// 4x4 membrane keypad emulator: answers the decoder's row scan with the column of a
// commanded key, closing the contact with bounce, press and release timing.
module emulador_de_teclado #(
  parameter int PRESS_CYCLES   = 200,
  parameter int RELEASE_CYCLES = 100,
  parameter int BOUNCE_TOGGLES = 3,
  parameter int BOUNCE_PERIOD  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            lin_matriz,
  output logic [3:0]            col_matriz,
  emulador_de_teclado_if.slave  key_if
);

  localparam int BURST = 2 * BOUNCE_TOGGLES;
  localparam int MAX_A = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int MAX_B = (BOUNCE_PERIOD > BURST) ? BOUNCE_PERIOD : BURST;
  localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAXP < 1) ? 1 : $clog2(MAXP + 1);

  localparam logic [CW-1:0] ZERO      = CW'(0);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] L_PRESS   = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] L_RELEASE = CW'(RELEASE_CYCLES - 1);
  localparam logic [CW-1:0] L_PERIOD  = CW'(BOUNCE_PERIOD - 1);
  localparam logic [CW-1:0] L_SUB     = CW'(BURST - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BOUNCE_IN  = 3'd1,
    S_PRESSED    = 3'd2,
    S_BOUNCE_OUT = 3'd3,
    S_RELEASED   = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  function automatic logic [3:0] key_row(input logic [3:0] k);
    case (k)
      4'h1, 4'h2, 4'h3: key_row = 4'b0111;
      4'h4, 4'h5, 4'h6: key_row = 4'b1011;
      4'h7, 4'h8, 4'h9: key_row = 4'b1101;
      4'hA, 4'h0, 4'hB: key_row = 4'b1110;
      default:          key_row = 4'b1111;
    endcase
  endfunction

  function automatic logic [3:0] key_col(input logic [3:0] k);
    case (k)
      4'h1, 4'h4, 4'h7, 4'hA: key_col = 4'b0111;
      4'h2, 4'h5, 4'h8, 4'h0: key_col = 4'b1011;
      4'h3, 4'h6, 4'h9, 4'hB: key_col = 4'b1101;
      default:                key_col = 4'b1111;
    endcase
  endfunction

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [CW-1:0] r_sub;
  logic [CW-1:0] w_sub_next;
  logic [3:0]    r_key;
  logic          w_accept;
  logic          w_bad_start;
  logic          r_contact;
  logic          w_contact_next;
  logic          w_ready_next;
  logic          w_busy_next;
  logic          w_done_next;
  logic          r_key_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_key_err;
  logic [3:0]    w_row;
  logic [3:0]    w_col;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and counter logic; cnt times a phase or a bounce sub-interval, sub counts sub-intervals
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_sub_next   = r_sub;
    w_accept     = 1'b0;
    w_bad_start  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (key_if.key_start) begin
          if (key_if.key_value <= 4'hB) begin
            w_accept = 1'b1;
            if (BOUNCE_TOGGLES == 0) begin
              w_next_state = S_PRESSED;
              w_cnt_next   = L_PRESS;
            end else begin
              w_next_state = S_BOUNCE_IN;
              w_cnt_next   = L_PERIOD;
              w_sub_next   = L_SUB;
            end
          end else begin
            w_bad_start = 1'b1;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_BOUNCE_IN: begin
        if (r_cnt == ZERO) begin
          if (r_sub == ZERO) begin
            w_next_state = S_PRESSED;
            w_cnt_next   = L_PRESS;
          end else begin
            w_sub_next = r_sub - ONE;
            w_cnt_next = L_PERIOD;
          end
        end else begin
          w_cnt_next = r_cnt - ONE;
        end
      end
      S_PRESSED: begin
        if (r_cnt == ZERO) begin
          if (BOUNCE_TOGGLES == 0) begin
            w_next_state = S_RELEASED;
            w_cnt_next   = L_RELEASE;
          end else begin
            w_next_state = S_BOUNCE_OUT;
            w_cnt_next   = L_PERIOD;
            w_sub_next   = L_SUB;
          end
        end else begin
          w_cnt_next = r_cnt - ONE;
        end
      end
      S_BOUNCE_OUT: begin
        if (r_cnt == ZERO) begin
          if (r_sub == ZERO) begin
            w_next_state = S_RELEASED;
            w_cnt_next   = L_RELEASE;
          end else begin
            w_sub_next = r_sub - ONE;
            w_cnt_next = L_PERIOD;
          end
        end else begin
          w_cnt_next = r_cnt - ONE;
        end
      end
      S_RELEASED: begin
        if (r_cnt == ZERO) begin
          w_next_state = S_DONE;
        end else begin
          w_cnt_next = r_cnt - ONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state; sub counts down from an odd value, so its LSB marks closed phases
  always_comb begin
    w_contact_next = 1'b0;
    w_ready_next   = (w_next_state == S_IDLE);
    w_busy_next    = (w_next_state != S_IDLE);
    w_done_next    = (w_next_state == S_DONE);
    case (w_next_state)
      S_BOUNCE_IN:  w_contact_next = w_sub_next[0];
      S_PRESSED:    w_contact_next = 1'b1;
      S_BOUNCE_OUT: w_contact_next = ~w_sub_next[0];
      default:      w_contact_next = 1'b0;
    endcase
  end

  // Counters and latched key
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= ZERO;
      r_sub <= ZERO;
      r_key <= 4'hF;
    end else begin
      r_cnt <= w_cnt_next;
      r_sub <= w_sub_next;
      if (w_accept) begin
        r_key <= key_if.key_value;
      end else begin
        r_key <= r_key;
      end
    end
  end

  // Registered contact and handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_contact   <= 1'b0;
      r_key_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_key_err   <= 1'b0;
    end else begin
      r_contact   <= w_contact_next;
      r_key_ready <= w_ready_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_key_err   <= w_bad_start;
    end
  end

  // The decoder samples columns in the same cycle it drives rows, so this path has no register
  assign w_row      = key_row(r_key);
  assign w_col      = key_col(r_key);
  assign col_matriz = (r_contact && (lin_matriz == w_row)) ? w_col : 4'b1111;

  assign key_if.key_ready = r_key_ready;
  assign key_if.busy      = r_busy;
  assign key_if.done      = r_done;
  assign key_if.key_err   = r_key_err;

endmodule

// File: doc/emulador_de_teclado.md
Name: emulador_de_teclado

Overview:
- Behavioural/synthesizable model of the 4x4 membrane keypad: the device end of the row-scan matrix interface driven by the keypad decoder (`lin_matriz` in, `col_matriz` out).
- Accepts one key command at a time through a ready/start handshake. Closes the matching contact with configurable bounce, press and release timing, then pulses `done`.
- Used in lock testbenches and FPGA self-test, in place of the physical keypad, to inject full password sequences.

Parameters:
- PRESS_CYCLES, 200, cycles the contact stays stably closed.
- RELEASE_CYCLES, 100, cycles the contact stays stably open after release bounce, before `done`.
- BOUNCE_TOGGLES, 3, closed/open pairs in each bounce burst; 0 disables bounce.
- BOUNCE_PERIOD, 2, cycles per bounce sub-interval; must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low
- lin_matriz  input  4  row drive from decoder; active row = 0
- col_matriz  output  4  column return; active column = 0; idle 4'b1111
- key_value  input  4  key code: 0-9 digits, 4'hA = *, 4'hB = #
- key_start  input  1  command request; sampled only when `key_ready` = 1
- key_ready  output  1  1 only in IDLE
- busy  output  1  1 in any state other than IDLE
- done  output  1  one-cycle pulse at end of release gap
- key_err  output  1  one-cycle pulse when a start carries code 4'hC-4'hF

Behaviour:
- Reset (`rst` = 0, asynchronous):
  - state IDLE, contact open.
  - `col_matriz` = 4'b1111, `key_ready` = 1, `busy` = 0, `done` = 0, `key_err` = 0.
  - latched key = 4'hF.
  - Reset mid-operation aborts immediately; no `done` is produced.
- Key map (row pattern, column pattern):
  - 1 (0111,0111), 2 (0111,1011), 3 (0111,1101)
  - 4 (1011,0111), 5 (1011,1011), 6 (1011,1101)
  - 7 (1101,0111), 8 (1101,1011), 9 (1101,1101)
  - * (1110,0111), 0 (1110,1011), # (1110,1101)
- Column path:
  - Combinational from `lin_matriz`, the registered contact bit and the registered key row/column.
  - `col_matriz` = key column when contact closed AND `lin_matriz` == key row exactly; else 4'b1111.
  - Zero latency from `lin_matriz`, required because the decoder samples columns in the same cycle it drives rows.
  - `lin_matriz` not exactly one-hot-low (e.g. 0011, 1111, 0000) gives 4'b1111.
- Handshake:
  - At a rising clk edge with `key_ready` = 1 and `key_start` = 1:
    - valid code: latch row/column, go to BOUNCE_IN.
    - code >= 4'hC: pulse `key_err` next cycle, stay IDLE.
  - `key_start` while busy is ignored, not queued.
  - `key_value` is don't-care except at accept.
- State machine (one down-counter `cnt`, one sub-interval counter `sub`):
  - IDLE: as above.
  - BOUNCE_IN: 2*BOUNCE_TOGGLES sub-intervals of BOUNCE_PERIOD cycles each. Contact closed, open, closed, open ..., starting closed and ending open. Skipped if BOUNCE_TOGGLES = 0.
  - PRESSED: contact closed for PRESS_CYCLES cycles.
  - BOUNCE_OUT: 2*BOUNCE_TOGGLES sub-intervals, starting open and ending closed. Skipped if BOUNCE_TOGGLES = 0.
  - RELEASED: contact open for RELEASE_CYCLES cycles.
  - DONE: one cycle; `done` = 1, `busy` = 1, `key_ready` = 0; next state IDLE.
- Timing:
  - Cycles from accept edge to DONE = 4*BOUNCE_TOGGLES*BOUNCE_PERIOD + PRESS_CYCLES + RELEASE_CYCLES.
  - Defaults: 24 + 200 + 100 = 324.
  - Back-to-back: a start presented in the first IDLE cycle after DONE is accepted.
- Counters:
  - Sized by $clog2(max param + 1).
  - Counters load param-1 on state entry and advance state at 0.
  - No wrap-around.

Test Plan:
- Press '5' (defaults), decoder-style scan rotating `lin_matriz` every cycle:
  - `col_matriz` = 1011 only when `lin_matriz` = 1011 during closed intervals; 1111 otherwise.
  - `done` exactly 324 cycles after accept; decoder-side capture yields digit 5.
- BOUNCE_TOGGLES = 2, BOUNCE_PERIOD = 3, key '#', `lin_matriz` held 1110:
  - `col_matriz` follows 1101×3, 1111×3, 1101×3, 1111×3, then 1101×PRESS_CYCLES.
  - Then mirrored release bounce (1111×3, 1101×3, 1111×3, 1101×3), then 1111×RELEASE_CYCLES.
- `key_value` = 4'hC with `key_start` in IDLE:
  - `key_err` one-cycle pulse, `busy` stays 0, `col_matriz` stays 1111.
- Second `key_start` ('7') asserted mid-PRESSED of key '1':
  - ignored; exactly one `done`.
  - `col_matriz` never reports row 1101.
- `rst` low asynchronously mid-PRESSED of '9' with `lin_matriz` = 1101:
  - `col_matriz` = 1111 immediately without a clock edge.
  - `key_ready` = 1, no `done`.
- Key '0' pressed, `lin_matriz` forced to 0110, 0000, 1111:
  - `col_matriz` = 1111 in all cases.
  - Returning `lin_matriz` to 1110 yields 1011 in the same cycle.
